// File: rtl/riscv_tracer_defines.sv
// Shared types for the retirement trace FIFO: record layout, instruction class
// encoding and the RISC-V major opcodes used by the classifier.
package riscv_tracer_defines;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 6;
    localparam int unsigned CLS_W = 3;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [CLS_W-1:0] {
        TC_OTHER  = 3'd0,
        TC_ALU    = 3'd1,
        TC_BRANCH = 3'd2,
        TC_LOAD   = 3'd3,
        TC_STORE  = 3'd4,
        TC_MULDIV = 3'd5,
        TC_SYSTEM = 3'd6,
        TC_FP     = 3'd7
    } trace_class_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] rd_data;
        logic            pending;
    } trace_rec_t;

endpackage

// File: rtl/riscv_trace_classifier.sv
// Maps an instruction's opcode/funct7 onto the tracer class encoding.
// Only instantiated when RISCV_TRACE_CLASS_EN is defined.
module riscv_trace_classifier
    import riscv_tracer_defines::*;
(
    input  logic [6:0]   opcode,
    input  logic [6:0]   funct7,
    output trace_class_e class_c
);

    always_comb begin
        class_c = TC_OTHER;
        case (opcode)
            OPC_OP:                                   class_c = (funct7 == FUNCT7_MULDIV) ? TC_MULDIV : TC_ALU;
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC:           class_c = TC_ALU;
            OPC_BRANCH, OPC_JAL, OPC_JALR:            class_c = TC_BRANCH;
            OPC_LOAD:                                 class_c = TC_LOAD;
            OPC_STORE:                                class_c = TC_STORE;
            OPC_SYSTEM:                               class_c = TC_SYSTEM;
            OPC_LOAD_FP, OPC_STORE_FP, OPC_OP_FP,
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: class_c = TC_FP;
            default:                                  class_c = TC_OTHER;
        endcase
    end

endmodule

// File: rtl/riscv_trace_fifo.sv
// In-order retirement trace FIFO with late-writeback completion of pending records.
// Optional head classification output when RISCV_TRACE_CLASS_EN is defined.
module riscv_trace_fifo
    import riscv_tracer_defines::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            retire_valid_i,
    input  logic [31:0]     retire_pc_i,
    input  logic [31:0]     retire_instr_i,
    input  logic [5:0]      retire_rd_i,
    input  logic [31:0]     retire_rd_data_i,
    input  logic            retire_wb_pending_i,
    input  logic            wb_valid_i,
    input  logic [5:0]      wb_rd_i,
    input  logic [31:0]     wb_data_i,
    output logic            trace_valid_o,
    input  logic            trace_ready_i,
    output logic [31:0]     trace_pc_o,
    output logic [31:0]     trace_instr_o,
    output logic [5:0]      trace_rd_o,
    output logic [31:0]     trace_rd_data_o,
    output logic            full_o,
    output logic            overflow_o
`ifdef RISCV_TRACE_CLASS_EN
    ,
    output logic [2:0]      trace_class_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    trace_rec_t       mem [DEPTH];
    trace_rec_t       head;
    trace_rec_t       new_rec;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             is_full;
    logic             wb_hit;
    logic [PTR_W-1:0] wb_idx;

    assign head          = mem[rd_ptr];
    assign is_full       = (count == CNT_W'(DEPTH));
    assign trace_valid_o = rst_n && (count != '0) && !head.pending;
    assign full_o        = rst_n && is_full;
    assign pop           = trace_valid_o && trace_ready_i;
    assign push          = retire_valid_i && (!is_full || pop);

    assign trace_pc_o      = head.pc;
    assign trace_instr_o   = head.instr;
    assign trace_rd_o      = head.rd;
    assign trace_rd_data_o = head.rd_data;

    always_comb begin
        new_rec         = '0;
        new_rec.pc      = retire_pc_i;
        new_rec.instr   = retire_instr_i;
        new_rec.rd      = retire_rd_i;
        new_rec.rd_data = retire_rd_data_i;
        new_rec.pending = retire_wb_pending_i;
    end

    // Oldest-first search over occupied slots only, so a same-cycle push never matches.
    always_comb begin
        wb_hit = 1'b0;
        wb_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_valid_i && !wb_hit && (CNT_W'(i) < count)
                && mem[PTR_W'(rd_ptr + PTR_W'(i))].pending
                && (mem[PTR_W'(rd_ptr + PTR_W'(i))].rd == wb_rd_i)) begin
                wb_hit = 1'b1;
                wb_idx = PTR_W'(rd_ptr + PTR_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (wb_hit) begin
                mem[wb_idx].rd_data <= wb_data_i;
                mem[wb_idx].pending <= 1'b0;
            end
            if (push) begin
                mem[wr_ptr] <= new_rec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (retire_valid_i && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef RISCV_TRACE_CLASS_EN
    trace_class_e head_class;

    riscv_trace_classifier u_classifier (
        .opcode  (head.instr[6:0]),
        .funct7  (head.instr[31:25]),
        .class_c (head_class)
    );

    assign trace_class_o = head_class;
`endif

endmodule

// File: doc/riscv_trace_fifo.md
RISCV_TRACE_FIFO -- requirements
Module: riscv_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of retirement record slots; a power of two, 2..16.
REQ-002 SHALL have port clk  input  1  core clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port retire_valid_i  input  1  an instruction retires this cycle.
REQ-005 SHALL have port retire_pc_i  input  32  PC of the retiring instruction.
REQ-006 SHALL have port retire_instr_i  input  32  decompressed instruction word.
REQ-007 SHALL have port retire_rd_i  input  6  destination register; bit 5 selects the FP file.
REQ-008 SHALL have port retire_rd_data_i  input  32  writeback data, valid when not pending.
REQ-009 SHALL have port retire_wb_pending_i  input  1  writeback arrives later (load, div, FP).
REQ-010 SHALL have port wb_valid_i  input  1  late writeback strobe.
REQ-011 SHALL have port wb_rd_i  input  6  late writeback register.
REQ-012 SHALL have port wb_data_i  input  32  late writeback data.
REQ-013 SHALL have port trace_valid_o  output  1  head record is complete.
REQ-014 SHALL have port trace_ready_i  input  1  tracer consumes the head record.
REQ-015 SHALL have ports trace_pc_o / trace_instr_o / trace_rd_o / trace_rd_data_o  output  32/32/6/32  head record fields.
REQ-016 SHALL have port full_o  output  1  all DEPTH slots occupied.
REQ-017 SHALL have port overflow_o  output  1  sticky: at least one record dropped since reset.

Function
REQ-018 SHALL push a record on retire_valid_i when not full, or when full and the head pops in the same cycle.
REQ-019 SHALL store each record with a pending flag equal to retire_wb_pending_i.
REQ-020 SHALL, on wb_valid_i, write wb_data_i into the oldest occupied pending entry whose rd equals wb_rd_i, and clear its pending flag.
REQ-021 SHALL NOT match a late writeback against the record being pushed in the same cycle.
REQ-022 SHALL ignore a late writeback that matches no pending entry.
REQ-023 SHALL assert trace_valid_o combinationally iff the FIFO is non-empty and the head entry is not pending.
REQ-024 SHALL pop the head when trace_valid_o and trace_ready_i are both high; no combinational path from trace_ready_i to trace_valid_o.
REQ-025 SHALL keep records strictly in retirement order; a pending head blocks younger complete records.
REQ-026 SHALL, when retire_valid_i is high while full and not popping, drop the new record and set overflow_o on the next edge.
REQ-027 SHALL use wrap-around read/write pointers with an occupancy counter of width $clog2(DEPTH)+1.
REQ-028 SHALL have a minimum latency of one cycle from a non-pending retire to trace_valid_o.
REQ-029 SHALL have a minimum latency of one cycle from the matching wb_valid_i to trace_valid_o.
REQ-030 SHALL hold the head output fields stable while trace_valid_o is high and trace_ready_i is low.

Reset
REQ-031 SHALL, with rst_n low at a clock edge, clear the occupancy counter, both pointers, all pending flags and overflow_o.
REQ-032 SHALL drive trace_valid_o=0, full_o=0 and overflow_o=0 during and after reset; data fields are don't-care, reset to 0.
REQ-033 SHALL discard all records on reset asserted mid-operation; no partial output afterwards.

Configuration
REQ-034 SHALL, with macro RISCV_TRACE_CLASS_EN defined, add output trace_class_o (3 bits) classifying the head instr.
REQ-035 SHALL encode trace_class_o using the tracer instruction masks: 0 other, 1 ALU, 2 branch/jump, 3 load, 4 store, 5 mul/div, 6 CSR/system, 7 FP.
REQ-036 SHALL, without RISCV_TRACE_CLASS_EN, omit the trace_class_o port and all classification logic.

Structure
REQ-037 SHALL define the trace record struct and the trace class enum in the riscv_tracer_defines package.
REQ-038 SHALL place classification in sub-module riscv_trace_classifier, instantiated only under RISCV_TRACE_CLASS_EN.

Verification
REQ-039 SHALL cover: retire pc=0x80 instr=0x00500093 rd=1 data=5 not pending, ready=1 -> next cycle valid=1 with those fields; popped.
REQ-040 SHALL cover: pending load rd=10 at pc=0x100, then ALU retire at pc=0x104 -> valid=0 until wb rd=10 data=0xDEAD; then 0x100 (data 0xDEAD) is output before 0x104.
REQ-041 SHALL cover: DEPTH=4, ready=0, 5 retires -> full_o=1 after the 4th; 5th dropped; overflow_o=1 and stays 1; 4 records drain intact.
REQ-042 SHALL cover: full, retire and pop in the same cycle -> no overflow; occupancy stays 4.
REQ-043 SHALL cover: two pending entries both with rd=5, one wb rd=5 -> only the older entry is completed.
REQ-044 SHALL cover: rst_n low for 1 cycle with 3 records queued -> valid=0, full=0, overflow=0 next cycle; with RISCV_TRACE_CLASS_EN, instr 0x0000A103 -> class 3.
